// File: rtl/cache_control_nway.sv
// Control FSM for an N-way write-back, write-allocate cache: hit service, dirty
// eviction, line fill and saturating hit/miss/writeback counters.
module cache_control_nway #(
   parameter  int WAYS  = 4,
   parameter  int CNT_W = 32,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic             mem_resp,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   input  logic             hit,
   input  logic [WAY_W-1:0] hit_way,
   input  logic [WAY_W-1:0] victim_way,
   input  logic             victim_valid,
   input  logic             victim_dirty,
   output logic [WAY_W-1:0] way_sel,
   output logic [WAYS-1:0]  load_data,
   output logic             data_src,
   output logic [WAYS-1:0]  load_tag,
   output logic [WAYS-1:0]  load_valid,
   output logic [WAYS-1:0]  load_dirty,
   output logic             dirty_value,
   output logic             load_plru,
   output logic             pmem_addr_sel,
   input  logic             perf_clr,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);

   typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

   localparam logic [WAYS-1:0]  WAY_ONE = {{(WAYS-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [WAY_W-1:0] vway_q, vway_d;
   logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d, wbc_q, wbc_d;
   logic [WAY_W-1:0] way_sel_c;
   logic             hit_inc, miss_inc, wb_inc, req;

   function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
      return WAY_ONE << w;
   endfunction

   // Clear wins over increment; increments stop at all-ones.
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c,
                                             input logic inc, input logic clr);
      if (clr) return '0;
      if (inc && (c != '1)) return c + CNT_ONE;
      return c;
   endfunction

   assign req = mem_read | mem_write;

   always_comb begin
      state_d       = state_q;
      vway_d        = vway_q;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      way_sel_c     = hit_way;
      load_data     = '0;
      data_src      = 1'b0;
      load_tag      = '0;
      load_valid    = '0;
      load_dirty    = '0;
      dirty_value   = 1'b0;
      load_plru     = 1'b0;
      pmem_addr_sel = 1'b0;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;
      wb_inc        = 1'b0;
      case (state_q)
         IDLE: if (req) state_d = CHECK;
         CHECK: begin
            state_d = IDLE;
            if (req && hit) begin
               mem_resp  = 1'b1;
               load_plru = 1'b1;
               hit_inc   = 1'b1;
               if (mem_write) begin
                  load_data   = onehot(hit_way);
                  load_dirty  = onehot(hit_way);
                  dirty_value = 1'b1;
               end
            end else if (req) begin
               vway_d   = victim_way;
               miss_inc = 1'b1;
               if (victim_valid && victim_dirty) begin
                  wb_inc  = 1'b1;
                  state_d = WB;
               end else begin
                  state_d = FILL;
               end
            end
         end
         WB: begin
            pmem_write    = 1'b1;
            pmem_addr_sel = 1'b1;
            way_sel_c     = vway_q;
            if (pmem_resp) state_d = FILL;
         end
         FILL: begin
            pmem_read = 1'b1;
            way_sel_c = vway_q;
            // Fill lands clean; the re-check hit path applies any CPU write.
            if (pmem_resp) begin
               load_data  = onehot(vway_q);
               data_src   = 1'b1;
               load_tag   = onehot(vway_q);
               load_valid = onehot(vway_q);
               load_dirty = onehot(vway_q);
               state_d    = CHECK;
            end
         end
         default: state_d = IDLE;
      endcase
      hit_d  = bump(hit_q,  hit_inc,  perf_clr);
      miss_d = bump(miss_q, miss_inc, perf_clr);
      wbc_d  = bump(wbc_q,  wb_inc,   perf_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vway_q  <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
         wbc_q   <= '0;
      end else begin
         state_q <= state_d;
         vway_q  <= vway_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         wbc_q   <= wbc_d;
      end
   end

   // Every output reads zero while reset is held, including the way select.
   assign way_sel    = rst_n ? way_sel_c : '0;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;
   assign wb_count   = wbc_q;

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench: transaction-level expectations per cycle plus event-count model.
module tb_cache_control_nway;
   localparam int WAYS = 4;

   typedef struct packed {
      logic       mem_resp, pmem_read, pmem_write;
      logic [1:0] way_sel;
      logic [3:0] load_data;
      logic       data_src;
      logic [3:0] load_tag, load_valid, load_dirty;
      logic       dirty_value, load_plru, pmem_addr_sel;
   } exp_t;

   logic clk = 1'b0, rst_n;
   logic mem_read, mem_write, pmem_resp, hit, victim_valid, victim_dirty, perf_clr;
   logic [1:0] hit_way, victim_way;
   logic mem_resp, pmem_read, pmem_write, data_src, dirty_value, load_plru, pmem_addr_sel;
   logic [1:0] way_sel;
   logic [3:0] load_data, load_tag, load_valid, load_dirty;
   logic [31:0] hit_count, miss_count, wb_count;
   logic d2_mem_resp, d2_pmem_read, d2_pmem_write, d2_data_src, d2_dirty_value;
   logic d2_load_plru, d2_pmem_addr_sel;
   logic [1:0] d2_way_sel, d2_hit_count, d2_miss_count, d2_wb_count;
   logic [3:0] d2_load_data, d2_load_tag, d2_load_valid, d2_load_dirty;

   exp_t exp;
   bit   chk_en = 1'b0;
   int   m_hit = 0, m_miss = 0, m_wb = 0;
   int   checks = 0, errors = 0;

   always #5 clk = ~clk;

   cache_control_nway #(.WAYS(WAYS), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_resp(pmem_resp), .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
      .victim_valid(victim_valid), .victim_dirty(victim_dirty), .way_sel(way_sel),
      .load_data(load_data), .data_src(data_src), .load_tag(load_tag),
      .load_valid(load_valid), .load_dirty(load_dirty), .dirty_value(dirty_value),
      .load_plru(load_plru), .pmem_addr_sel(pmem_addr_sel), .perf_clr(perf_clr),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count));

   cache_control_nway #(.WAYS(WAYS), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_resp(d2_mem_resp), .pmem_read(d2_pmem_read), .pmem_write(d2_pmem_write),
      .pmem_resp(pmem_resp), .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
      .victim_valid(victim_valid), .victim_dirty(victim_dirty), .way_sel(d2_way_sel),
      .load_data(d2_load_data), .data_src(d2_data_src), .load_tag(d2_load_tag),
      .load_valid(d2_load_valid), .load_dirty(d2_load_dirty), .dirty_value(d2_dirty_value),
      .load_plru(d2_load_plru), .pmem_addr_sel(d2_pmem_addr_sel), .perf_clr(perf_clr),
      .hit_count(d2_hit_count), .miss_count(d2_miss_count), .wb_count(d2_wb_count));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   function automatic logic [31:0] sat(input int v, input int mx);
      return (v > mx) ? 32'(mx) : 32'(v);
   endfunction

   function automatic logic [3:0] oh(input logic [1:0] i);
      logic [3:0] one = 4'b0001;
      return one << i;
   endfunction

   function automatic exp_t idle_exp();
      exp_t e = '0;
      e.way_sel = hit_way;
      return e;
   endfunction

   always @(negedge clk) if (chk_en) begin
      chk("mem_resp", 32'(mem_resp), 32'(exp.mem_resp));
      chk("pmem_read", 32'(pmem_read), 32'(exp.pmem_read));
      chk("pmem_write", 32'(pmem_write), 32'(exp.pmem_write));
      chk("way_sel", 32'(way_sel), 32'(exp.way_sel));
      chk("load_data", 32'(load_data), 32'(exp.load_data));
      chk("data_src", 32'(data_src), 32'(exp.data_src));
      chk("load_tag", 32'(load_tag), 32'(exp.load_tag));
      chk("load_valid", 32'(load_valid), 32'(exp.load_valid));
      chk("load_dirty", 32'(load_dirty), 32'(exp.load_dirty));
      chk("dirty_value", 32'(dirty_value), 32'(exp.dirty_value));
      chk("load_plru", 32'(load_plru), 32'(exp.load_plru));
      chk("pmem_addr_sel", 32'(pmem_addr_sel), 32'(exp.pmem_addr_sel));
      chk("hit_count", hit_count, sat(m_hit, 32'h7fffffff));
      chk("miss_count", miss_count, sat(m_miss, 32'h7fffffff));
      chk("wb_count", wb_count, sat(m_wb, 32'h7fffffff));
      chk("hit_count_w2", 32'(d2_hit_count), sat(m_hit, 3));
      chk("miss_count_w2", 32'(d2_miss_count), sat(m_miss, 3));
      chk("wb_count_w2", 32'(d2_wb_count), sat(m_wb, 3));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Completion through the hit path (initial hit or post-fill re-check).
   task automatic hit_cycle(input bit wr, input logic [1:0] hw, input bit clr);
      hit = 1'b1; hit_way = hw; perf_clr = clr;
      exp = idle_exp();
      exp.mem_resp = 1'b1; exp.load_plru = 1'b1;
      if (wr) begin
         exp.load_data = oh(hw); exp.load_dirty = oh(hw); exp.dirty_value = 1'b1;
      end
      step();
      if (clr) begin m_hit = 0; m_miss = 0; m_wb = 0; end
      else m_hit++;
      perf_clr = 1'b0;
   endtask

   task automatic txn(input logic [1:0] rq, input bit hit0, input logic [1:0] hw,
                      input logic [1:0] vw, input bit vv, input bit vd,
                      input int wb_n, input int fill_n, input bit drop, input bit clr);
      mem_read = rq[0]; mem_write = rq[1];
      hit = hit0; hit_way = hw; victim_way = vw; victim_valid = vv; victim_dirty = vd;
      exp = idle_exp();
      step();
      if (hit0) hit_cycle(rq[1], hw, clr);
      else begin
         exp = idle_exp();
         step();
         m_miss++;
         if (vv && vd) m_wb++;
         if (vv && vd) for (int i = 0; i <= wb_n; i++) begin
            victim_way = ~vw;
            pmem_resp = (i == wb_n);
            exp = idle_exp();
            exp.pmem_write = 1'b1; exp.pmem_addr_sel = 1'b1; exp.way_sel = vw;
            step();
         end
         for (int i = 0; i <= fill_n; i++) begin
            if (drop) begin mem_read = 1'b0; mem_write = 1'b0; end
            pmem_resp = (i == fill_n);
            exp = idle_exp();
            exp.pmem_read = 1'b1; exp.way_sel = vw;
            if (i == fill_n) begin
               exp.load_data = oh(vw); exp.data_src = 1'b1; exp.load_tag = oh(vw);
               exp.load_valid = oh(vw); exp.load_dirty = oh(vw);
            end
            step();
         end
         pmem_resp = 1'b0;
         if (drop) begin
            hit = 1'b1; hit_way = vw;
            exp = idle_exp();
            step();
         end else hit_cycle(rq[1], vw, clr);
      end
      mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0;
      exp = idle_exp();
   endtask

   initial begin
      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0; hit = 1'b0;
      hit_way = 2'd0; victim_way = 2'd0; victim_valid = 1'b0; victim_dirty = 1'b0;
      perf_clr = 1'b0;
      exp = '0;
      chk_en = 1'b1;
      step(); step();
      rst_n = 1'b1;
      exp = idle_exp();
      step();

      txn(2'b01, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);  // read hit way 2
      chk("lit_hit_after_read_hit", hit_count, 32'd1);
      txn(2'b11, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);  // write hit way 3
      chk("lit_hit_after_write_hit", hit_count, 32'd2);
      txn(2'b01, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 0, 4, 1'b0, 1'b0);  // clean read miss
      chk("lit_miss_after_read_miss", miss_count, 32'd1);
      chk("lit_hit_after_read_miss", hit_count, 32'd3);
      txn(2'b10, 1'b0, 2'd1, 2'd0, 1'b1, 1'b1, 3, 2, 1'b0, 1'b0);  // dirty write miss
      chk("lit_wb_after_dirty_miss", wb_count, 32'd1);
      chk("lit_miss_after_dirty_miss", miss_count, 32'd2);
      txn(2'b01, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 0, 1, 1'b1, 1'b0);  // request dropped in FILL
      chk("lit_hit_after_drop", hit_count, 32'd4);
      chk("lit_miss_after_drop", miss_count, 32'd3);

      // Reset asserted mid-FILL
      mem_read = 1'b1; hit = 1'b0; victim_way = 2'd2; victim_valid = 1'b0; victim_dirty = 1'b0;
      exp = idle_exp();
      step();
      exp = idle_exp();
      step();
      m_miss++;
      exp = idle_exp(); exp.pmem_read = 1'b1; exp.way_sel = 2'd2;
      chk("fill_pmem_read", 32'(pmem_read), 32'd1);
      rst_n = 1'b0; mem_read = 1'b0;
      m_hit = 0; m_miss = 0; m_wb = 0;
      exp = '0;
      #1;
      chk("rst_pmem_read_drop", 32'(pmem_read), 32'd0);
      step(); step();
      rst_n = 1'b1; pmem_resp = 1'b1;
      exp = idle_exp();
      step();
      pmem_resp = 1'b0;
      step();
      chk("lit_hit_after_reset", hit_count, 32'd0);
      chk("lit_miss_after_reset", miss_count, 32'd0);
      chk("lit_wb_after_reset", wb_count, 32'd0);

      for (int i = 0; i < 5; i++)
         txn(2'b01, 1'b1, 2'(i), 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      chk("lit_hit_w2_saturated", 32'(d2_hit_count), 32'd3);
      chk("lit_hit_w32_five", hit_count, 32'd5);
      txn(2'b01, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);  // clear beats hit
      chk("lit_hit_after_clr", hit_count, 32'd0);
      chk("lit_hit_w2_after_clr", 32'(d2_hit_count), 32'd0);
      step();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end
endmodule

// File: doc/cache_control_nway.md
Name: cache_control_nway

Overview:
- Parametrised successor controller for an N-way set-associative, write-back, write-allocate cache. It sits between the CPU-side memory port and the physical-memory port.
- Drives datapath load strobes and the PLRU/dirty/valid/tag arrays.
- Handles dirty eviction (writeback followed by fill) and keeps saturating hit, miss and writeback performance counters.
- Datapath lookup (hit, hit_way, victim select) is external; this block is control only.

Parameters:
WAYS, 4, associativity; power of two, 2..16
WAY_W, $clog2(WAYS), way-index width (derived; not overridden)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  reset, asynchronous assert, active-low
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  one-cycle completion pulse to CPU
pmem_read  out  1  physical-memory line read, held until pmem_resp
pmem_write  out  1  physical-memory line write, held until pmem_resp
pmem_resp  in  1  physical-memory completion pulse
hit  in  1  lookup hit (combinational from datapath)
hit_way  in  WAY_W  hitting way; valid only when hit=1
victim_way  in  WAY_W  PLRU-selected replacement way
victim_valid  in  1  victim line valid bit
victim_dirty  in  1  victim line dirty bit
way_sel  out  WAY_W  way index for all load strobes below
load_data  out  WAYS  one-hot data-array write enable
data_src  out  1  0 = CPU write data (byte-masked), 1 = pmem line
load_tag  out  WAYS  one-hot tag write enable
load_valid  out  WAYS  one-hot valid-bit set
load_dirty  out  WAYS  one-hot dirty-bit write enable
dirty_value  out  1  value written to dirty bit
load_plru  out  1  update PLRU toward way_sel
pmem_addr_sel  out  1  0 = CPU address, 1 = {victim tag, set}
perf_clr  in  1  synchronous clear of all counters
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter
wb_count  out  CNT_W  saturating writeback counter

Behaviour:
- States: IDLE, CHECK, WB, FILL. Outputs are decoded combinationally from state and inputs. Default for every strobe is 0; default for way_sel is hit_way.
- Reset (rst_n=0, asynchronous):
  - state goes to IDLE; vway_q = 0; all counters = 0.
  - All outputs 0 while reset is held, including mid-WB/FILL: pmem_read/pmem_write drop immediately.
- IDLE: mem_read|mem_write -> CHECK. Otherwise stay. No outputs asserted.
- CHECK with hit=1:
  - mem_resp=1, load_plru=1, way_sel=hit_way.
  - If mem_write: additionally load_data[hit_way]=1, data_src=0, load_dirty[hit_way]=1, dirty_value=1.
  - hit_count+1; next state IDLE.
  - Hit latency: 2 cycles from request to mem_resp.
- CHECK with hit=0 and request still asserted:
  - Latch victim_way into vway_q; miss_count+1.
  - victim_valid & victim_dirty -> WB (wb_count+1); else -> FILL.
- CHECK with request deasserted: -> IDLE, no strobes, no counter change (protocol violation, tolerated).
- WB: pmem_write=1, pmem_addr_sel=1, way_sel=vway_q. On pmem_resp -> FILL.
- FILL: pmem_read=1, pmem_addr_sel=0, way_sel=vway_q. On pmem_resp:
  - load_data[vway_q]=1, data_src=1.
  - load_tag[vway_q]=1, load_valid[vway_q]=1.
  - load_dirty[vway_q]=1, dirty_value=0.
  - Next state CHECK, where the request re-looks-up and hits, so read and write completion share the hit path. That re-check hit increments hit_count.
- Miss latency = 1 (CHECK) + WB wait + FILL wait + 1 (re-CHECK).
- pmem_resp outside WB/FILL is ignored.
- mem_read & mem_write both high: treated as a write.
- Request dropped during WB/FILL: the miss still completes, then re-CHECK goes to IDLE with no mem_resp.
- Counters:
  - Saturate at 2^CNT_W-1 with no wrap.
  - perf_clr has priority over a same-cycle increment; the result is 0.
  - Counters are independent of state, so a clear mid-miss does not disturb the FSM.
- vway_q is stable from the CHECK miss cycle to the end of FILL, even if victim_way changes meanwhile.

Test Plan:
- Reset, then read hit, hit=1 hit_way=2 -> mem_resp on cycle 2, load_plru=1, way_sel=2, no load_data, hit_count=1.
- Write hit, hit_way=3, WAYS=4 -> load_data=4'b1000, load_dirty=4'b1000, dirty_value=1, data_src=0, mem_resp on cycle 2.
- Read miss, clean victim 1, pmem_resp after 5 cycles -> FILL strobes load_data/tag/valid/dirty=4'b0010 with dirty_value=0; re-CHECK hit then mem_resp; total latency 8 cycles; miss_count=1, hit_count=1.
- Write miss, dirty valid victim 0 -> WB with pmem_write=1 and pmem_addr_sel=1 until pmem_resp; then FILL; victim_way toggled during WB yet way_sel stays 0; wb_count=1; final write to way 0 sets dirty.
- rst_n low during FILL with pmem_read=1 -> pmem_read drops the same cycle; after release, state IDLE and all counters 0.
- CNT_W=2: 5 hits -> hit_count holds 3; perf_clr on the same cycle as a hit -> hit_count=0.
